// File: rtl/vga_pattern_pkg.sv
// Shared definitions for the VGA pattern generators: mode encoding and
// default timing/colour widths.
package vga_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_STATIC      = 2'd0,
    MODE_SCROLL_UP   = 2'd1,
    MODE_SCROLL_DOWN = 2'd2,
    MODE_BLINK       = 2'd3
  } pattern_mode_e;

  localparam int DEFAULT_V_ACTIVE = 480;
  localparam int DEFAULT_COLOR_W  = 10;

endpackage

// File: rtl/vga_frame_detect.sv
// Frame-start and row-change detection from the pixel row coordinate.
// A frame starts whenever the row number goes backwards.
module vga_frame_detect #(
  parameter int POS_W = 10
) (
  input  logic             vga_clk,
  input  logic             RST,
  input  logic [POS_W-1:0] yPos,
  output logic             new_frame,
  output logic             row_change,
  output logic             frame_tick
);

  logic [POS_W-1:0] prev_y_reg;

  // All-ones after reset makes the first live sample a frame start.
  assign new_frame  = (yPos < prev_y_reg);
  assign row_change = (yPos != prev_y_reg) && !new_frame;

  always_ff @(posedge vga_clk) begin
    if (RST) begin
      prev_y_reg <= '1;
      frame_tick <= 1'b0;
    end else begin
      prev_y_reg <= yPos;
      frame_tick <= new_frame;
    end
  end

endmodule

// File: rtl/line_pattern_gen.sv
// Horizontal band pattern generator: evenly spaced bands with static,
// scroll and blink modes; mode and colour change only at frame starts.
module line_pattern_gen
  import vga_pattern_pkg::*;
#(
  parameter int COLOR_W      = DEFAULT_COLOR_W,
  parameter int POS_W        = 10,
  parameter int V_ACTIVE     = DEFAULT_V_ACTIVE,
  parameter int LINE_PERIOD  = 60,
  parameter int LINE_THICK   = 9,
  parameter int LINE_COUNT   = 8,
  parameter int STEP         = 1,
  parameter int BLINK_FRAMES = 30
) (
  input  logic               vga_clk,
  input  logic               RST,
  input  logic [POS_W-1:0]   xPos,
  input  logic [POS_W-1:0]   yPos,
  input  logic [1:0]         mode,
  input  logic [COLOR_W-1:0] fg_red,
  input  logic [COLOR_W-1:0] fg_green,
  input  logic [COLOR_W-1:0] fg_blue,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue,
  output logic               frame_tick
);

  localparam int PH_W  = $clog2(LINE_PERIOD);
  localparam int IDX_W = $clog2(LINE_COUNT + 1);
  localparam int BC_W  = $clog2(BLINK_FRAMES + 1);

  localparam logic [PH_W:0]    PERIOD_X   = (PH_W + 1)'(LINE_PERIOD);
  localparam logic [PH_W:0]    STEP_X     = (PH_W + 1)'(STEP);
  localparam logic [PH_W-1:0]  STEP_C     = PH_W'(STEP);
  localparam logic [PH_W-1:0]  LAST_PHASE = PH_W'(LINE_PERIOD - 1);
  localparam logic [PH_W-1:0]  THICK_C    = PH_W'(LINE_THICK);
  localparam logic [IDX_W-1:0] IDX_MAX    = IDX_W'(LINE_COUNT);
  localparam logic [BC_W-1:0]  BLINK_LAST = BC_W'(BLINK_FRAMES - 1);
  localparam logic [POS_W-1:0] VA_C       = POS_W'(V_ACTIVE);

  logic new_frame, row_change;
  logic unused_xpos;

  pattern_mode_e      mode_reg, mode_next;
  logic [COLOR_W-1:0] red_sh_reg, green_sh_reg, blue_sh_reg;
  logic [COLOR_W-1:0] red_sh_next, green_sh_next, blue_sh_next;
  logic [PH_W-1:0]    offset_reg, offset_next, phase_reg, phase_next;
  logic [IDX_W-1:0]   line_idx_reg, line_idx_next;
  logic [BC_W-1:0]    blink_cnt_reg, blink_cnt_next;
  logic               visible_reg, visible_next;
  logic               hit;
  logic [PH_W:0]      up_sum, up_wrap, dn_wrap;
  logic [PH_W-1:0]    up_off, dn_off;

  assign unused_xpos = ^xPos;

  vga_frame_detect #(.POS_W(POS_W)) u_frame_detect (
    .vga_clk    (vga_clk),
    .RST        (RST),
    .yPos       (yPos),
    .new_frame  (new_frame),
    .row_change (row_change),
    .frame_tick (frame_tick)
  );

  // Modulo-period offset stepping, computed one bit wider to avoid overflow.
  assign up_sum  = {1'b0, offset_reg} + STEP_X;
  assign up_wrap = up_sum - PERIOD_X;
  assign up_off  = (up_sum >= PERIOD_X) ? up_wrap[PH_W-1:0] : up_sum[PH_W-1:0];
  assign dn_wrap = {1'b0, offset_reg} + PERIOD_X - STEP_X;
  assign dn_off  = (offset_reg < STEP_C) ? dn_wrap[PH_W-1:0] : offset_reg - STEP_C;

  always_comb begin
    mode_next      = mode_reg;
    red_sh_next    = red_sh_reg;
    green_sh_next  = green_sh_reg;
    blue_sh_next   = blue_sh_reg;
    offset_next    = offset_reg;
    blink_cnt_next = blink_cnt_reg;
    visible_next   = visible_reg;
    phase_next     = phase_reg;
    line_idx_next  = line_idx_reg;

    if (new_frame) begin
      mode_next     = pattern_mode_e'(mode);
      red_sh_next   = fg_red;
      green_sh_next = fg_green;
      blue_sh_next  = fg_blue;
      // Movement follows the mode latched one frame earlier.
      case (mode_reg)
        MODE_SCROLL_UP:   offset_next = up_off;
        MODE_SCROLL_DOWN: offset_next = dn_off;
        default:          offset_next = offset_reg;
      endcase
      if (mode_next != MODE_BLINK) begin
        blink_cnt_next = '0;
        visible_next   = 1'b1;
      end else if (mode_reg == MODE_BLINK) begin
        if (blink_cnt_reg == BLINK_LAST) begin
          blink_cnt_next = '0;
          visible_next   = !visible_reg;
        end else begin
          blink_cnt_next = blink_cnt_reg + BC_W'(1);
        end
      end
      phase_next    = offset_next;
      line_idx_next = '0;
    end else if (row_change) begin
      if (phase_reg == LAST_PHASE) begin
        phase_next = '0;
        if (line_idx_reg != IDX_MAX) line_idx_next = line_idx_reg + IDX_W'(1);
      end else begin
        phase_next = phase_reg + PH_W'(1);
      end
    end

    hit = (phase_next < THICK_C) && (line_idx_next < IDX_MAX) &&
          (yPos < VA_C) && visible_next;
  end

  always_ff @(posedge vga_clk) begin
    if (RST) begin
      mode_reg      <= MODE_STATIC;
      red_sh_reg    <= '0;
      green_sh_reg  <= '0;
      blue_sh_reg   <= '0;
      offset_reg    <= '0;
      blink_cnt_reg <= '0;
      visible_reg   <= 1'b1;
      phase_reg     <= '0;
      line_idx_reg  <= '0;
      red           <= '0;
      green         <= '0;
      blue          <= '0;
    end else begin
      mode_reg      <= mode_next;
      red_sh_reg    <= red_sh_next;
      green_sh_reg  <= green_sh_next;
      blue_sh_reg   <= blue_sh_next;
      offset_reg    <= offset_next;
      blink_cnt_reg <= blink_cnt_next;
      visible_reg   <= visible_next;
      phase_reg     <= phase_next;
      line_idx_reg  <= line_idx_next;
      red           <= hit ? red_sh_next   : '0;
      green         <= hit ? green_sh_next : '0;
      blue          <= hit ? blue_sh_next  : '0;
    end
  end

endmodule
